// File: rtl/qeciphy_crc_ctrl_pkg.sv
// Shared types and constants for the CRC16 frame controller.
package qeciphy_crc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } crc_ctrl_state_t;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam int          CRC_ENGINE_LAT = 2;

endpackage

// File: rtl/qeciphy_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last requester
// served and only moves when the owner signals frame completion.
module qeciphy_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       grant_o
);

  // Last-served pointer; resets to 1 so that req0 wins the first contest.
  logic last_q;

  // Record the requester that just completed a frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= served_i;
    end
  end

  // Contested request goes to whoever was not served last.
  always_comb begin
    grant_o = 1'b0;
    if (req_i == 2'b11) begin
      grant_o = ~last_q;
    end else if (req_i[1]) begin
      grant_o = 1'b1;
    end
  end

endmodule

// File: rtl/qeciphy_crc16_frame_ctrl.sv
// Frame-level owner of a shared 64-bit CRC16 engine: grants one requester
// per frame, reseeds the engine, forwards words, waits out the engine
// pipeline and returns the final CRC on a held result channel.
//
// state  | meaning
// IDLE   | waiting for any requester tvalid
// INIT   | one-cycle engine reseed, counters cleared
// FEED   | accepting words from the granted requester
// DRAIN  | waiting for outstanding engine updates to land
// RESULT | result held until consumer is ready
module qeciphy_crc16_frame_ctrl #(
  parameter int MAX_WORDS = 256,
  parameter int CRC_LAT   = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] req0_tdata_i,
  input  logic        req0_tvalid_i,
  input  logic        req0_tlast_i,
  output logic        req0_tready_o,
  input  logic [63:0] req1_tdata_i,
  input  logic        req1_tvalid_i,
  input  logic        req1_tlast_i,
  output logic        req1_tready_o,
  output logic        eng_init_o,
  output logic [63:0] eng_tdata_o,
  output logic        eng_tvalid_o,
  input  logic [15:0] eng_crc_i,
  input  logic        eng_crc_valid_i,
  output logic [15:0] res_crc_o,
  output logic        res_id_o,
  output logic        res_err_o,
  output logic        res_valid_o,
  input  logic        res_ready_i
);
  import qeciphy_crc_ctrl_pkg::*;

  localparam int              CW      = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_WORDS);

  // The drain logic assumes the fixed engine pipeline depth.
  if (CRC_LAT != CRC_ENGINE_LAT) begin : g_lat_check
    $error("qeciphy_crc16_frame_ctrl: CRC_LAT must equal the engine latency");
  end

  crc_ctrl_state_t state_q, state_d;
  logic            grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      out_q, out_d;
  logic            err_q, err_d;
  logic [15:0]     res_crc_q, res_crc_d;
  logic [63:0]     eng_tdata_q, eng_tdata_d;
  logic            eng_tvalid_q, eng_tvalid_d;

  logic            arb_grant;
  logic            sel_tvalid, sel_tlast;
  logic [63:0]     sel_tdata;
  logic            accept, dec;
  logic [CW-1:0]   cnt_inc;

  assign sel_tvalid = grant_q ? req1_tvalid_i : req0_tvalid_i;
  assign sel_tlast  = grant_q ? req1_tlast_i  : req0_tlast_i;
  assign sel_tdata  = grant_q ? req1_tdata_i  : req0_tdata_i;
  assign accept     = (state_q == FEED) && sel_tvalid;
  // Engine updates with nothing outstanding are stray and ignored.
  assign dec        = eng_crc_valid_i && (out_q != 2'd0);
  assign cnt_inc    = cnt_q + CW'(1);

  qeciphy_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    ({req1_tvalid_i, req0_tvalid_i}),
    .update_i ((state_q == RESULT) && res_ready_i),
    .served_i (grant_q),
    .grant_o  (arb_grant)
  );

  // Next-state, counters, engine word staging and result capture.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    res_crc_d    = res_crc_q;
    eng_tvalid_d = accept;
    eng_tdata_d  = accept ? sel_tdata : eng_tdata_q;
    case ({accept, dec})
      2'b10:   out_d = out_q + 2'd1;
      2'b01:   out_d = out_q - 2'd1;
      default: out_d = out_q;
    endcase
    case (state_q)
      IDLE: begin
        if (req0_tvalid_i || req1_tvalid_i) begin
          grant_d = arb_grant;
          state_d = INIT;
        end
      end
      INIT: begin
        cnt_d   = '0;
        out_d   = 2'd0;
        err_d   = 1'b0;
        state_d = FEED;
      end
      FEED: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (sel_tlast || (cnt_inc == MAX_CNT)) begin
            err_d   = ~sel_tlast;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dec && (out_q == 2'd1)) begin
          res_crc_d = eng_crc_i;
          state_d   = RESULT;
        end
      end
      RESULT: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      out_q        <= 2'd0;
      err_q        <= 1'b0;
      res_crc_q    <= CRC16_INIT;
      eng_tdata_q  <= '0;
      eng_tvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      err_q        <= err_d;
      res_crc_q    <= res_crc_d;
      eng_tdata_q  <= eng_tdata_d;
      eng_tvalid_q <= eng_tvalid_d;
    end
  end

  assign req0_tready_o = (state_q == FEED) && !grant_q;
  assign req1_tready_o = (state_q == FEED) &&  grant_q;
  assign eng_init_o    = (state_q == INIT);
  assign eng_tdata_o   = eng_tdata_q;
  assign eng_tvalid_o  = eng_tvalid_q;
  assign res_crc_o     = res_crc_q;
  assign res_id_o      = grant_q;
  assign res_err_o     = err_q;
  assign res_valid_o   = (state_q == RESULT);

endmodule

// File: tb/tb_qeciphy_crc16_frame_ctrl.sv
// Bench for the CRC16 frame controller with a behavioural engine stand-in
// and a per-requester frame model built from the word streams.
module tb_qeciphy_crc16_frame_ctrl;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] req0_tdata = '0, req1_tdata = '0;
  logic        req0_tvalid = 1'b0, req1_tvalid = 1'b0;
  logic        req0_tlast = 1'b0, req1_tlast = 1'b0;
  logic        req0_tready, req1_tready;
  logic        eng_init, eng_tvalid;
  logic [63:0] eng_tdata;
  logic [15:0] eng_crc = 16'hFFFF;
  logic        eng_crc_valid = 1'b0;
  logic [15:0] res_crc;
  logic        res_id, res_err, res_valid;
  logic        res_ready = 1'b0;

  always #5 clk = ~clk;

  qeciphy_crc16_frame_ctrl #(.MAX_WORDS(MAXW), .CRC_LAT(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_tdata_i(req0_tdata), .req0_tvalid_i(req0_tvalid), .req0_tlast_i(req0_tlast), .req0_tready_o(req0_tready),
    .req1_tdata_i(req1_tdata), .req1_tvalid_i(req1_tvalid), .req1_tlast_i(req1_tlast), .req1_tready_o(req1_tready),
    .eng_init_o(eng_init), .eng_tdata_o(eng_tdata), .eng_tvalid_o(eng_tvalid),
    .eng_crc_i(eng_crc), .eng_crc_valid_i(eng_crc_valid),
    .res_crc_o(res_crc), .res_id_o(res_id), .res_err_o(res_err), .res_valid_o(res_valid),
    .res_ready_i(res_ready)
  );

  // CRC16-IBM3740: poly 0x1021, MSB first, no reflection, no final xor.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [63:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 63; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // Engine stand-in: two-cycle pipeline from eng_tvalid to crc_valid.
  logic        p1_v = 1'b0;
  logic [63:0] p1_d = '0;
  always @(posedge clk) begin
    p1_v          <= eng_tvalid;
    p1_d          <= eng_tdata;
    eng_crc_valid <= p1_v;
    if (p1_v)          eng_crc <= crc_step(eng_crc, p1_d);
    else if (eng_init) eng_crc <= 16'hFFFF;
  end

  typedef struct packed { logic [63:0] d; logic last; } word_t;
  typedef struct packed { logic [15:0] crc; logic err; } res_t;
  typedef struct packed { logic id; logic [15:0] crc; logic err; } log_t;

  word_t       q0[$], q1[$];
  res_t        exp0[$], exp1[$];
  log_t        rlog[$];
  logic [15:0] acc_crc[2];
  int          acc_n[2];

  int total = 0, bad = 0;
  int cyc = 0, nacc0 = 0;
  int dens = 100, stall = 0, vcnt = 0;
  bit rand_stall = 0;
  int last_acc = -100, init_cyc = -100, hs_cyc = -100, want_init = -100;
  logic        pv = 1'b0, pr = 1'b0, pid = 1'b0, perr = 1'b0;
  logic [15:0] pcrc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: a frame closes on tlast or when it reaches MAXW words.
  task automatic push(input int r, input logic [63:0] d, input logic last);
    word_t w;
    res_t  e;
    w.d = d; w.last = last;
    if (r == 0) q0.push_back(w); else q1.push_back(w);
    acc_crc[r] = crc_step(acc_crc[r], d);
    acc_n[r]++;
    if (last || acc_n[r] == MAXW) begin
      e.crc = acc_crc[r];
      e.err = ~last;
      if (r == 0) exp0.push_back(e); else exp1.push_back(e);
      acc_crc[r] = 16'hFFFF;
      acc_n[r]   = 0;
    end
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete(); rlog.delete();
    acc_crc[0] = 16'hFFFF; acc_crc[1] = 16'hFFFF; acc_n[0] = 0; acc_n[1] = 0;
    last_acc = -100; init_cyc = -100; hs_cyc = -100; want_init = -100;
    pv = 1'b0; pr = 1'b0; vcnt = 0; nacc0 = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tready0"}, 64'(req0_tready), 64'd0);
    chk({tag, "_tready1"}, 64'(req1_tready), 64'd0);
    chk({tag, "_init"},    64'(eng_init),    64'd0);
    chk({tag, "_tdata"},   eng_tdata,        64'd0);
    chk({tag, "_tvalid"},  64'(eng_tvalid),  64'd0);
    chk({tag, "_crc"},     64'(res_crc),     64'hFFFF);
    chk({tag, "_id"},      64'(res_id),      64'd0);
    chk({tag, "_err"},     64'(res_err),     64'd0);
    chk({tag, "_valid"},   64'(res_valid),   64'd0);
  endtask

  // One clock: observe at negedge, then update stimulus just after posedge.
  task automatic tick();
    logic a0, a1, hs;
    res_t e;
    log_t l;
    @(negedge clk);
    cyc++;
    a0 = req0_tvalid & req0_tready;
    a1 = req1_tvalid & req1_tready;
    hs = res_valid & res_ready;
    if (rst_n) begin
      if (a0) nacc0++;
      if (a0 | a1) last_acc = cyc;
      chk("tready_excl", 64'(req0_tready & req1_tready), 64'd0);
      if (res_valid && !pv) chk("res_latency", 64'(cyc), 64'(last_acc + 4));
      if (pv && !pr) begin
        chk("res_hold",  64'(res_valid), 64'd1);
        chk("res_crc_stable", 64'(res_crc), 64'(pcrc));
        chk("res_id_stable",  64'(res_id),  64'(pid));
        chk("res_err_stable", 64'(res_err), 64'(perr));
      end
      if (cyc == init_cyc + 1) begin
        chk("init_pulse", 64'(eng_init), 64'd0);
        chk("tready_after_init", 64'(req0_tready | req1_tready), 64'd1);
      end
      if (eng_init) begin
        chk("init_while_result", 64'(res_valid), 64'd0);
        init_cyc = cyc;
      end
      if (cyc == want_init) chk("turnaround", 64'(eng_init), 64'd1);
      if (cyc == hs_cyc + 1 && (req0_tvalid | req1_tvalid)) want_init = cyc + 1;
      if (res_valid) vcnt++;
      if (hs) begin
        l.id = res_id; l.crc = res_crc; l.err = res_err;
        rlog.push_back(l);
        if (res_id == 1'b0) begin
          chk("exp0_avail", 64'(exp0.size() > 0), 64'd1);
          if (exp0.size() > 0) begin
            e = exp0.pop_front();
            chk("res_crc0", 64'(res_crc), 64'(e.crc));
            chk("res_err0", 64'(res_err), 64'(e.err));
          end
        end else begin
          chk("exp1_avail", 64'(exp1.size() > 0), 64'd1);
          if (exp1.size() > 0) begin
            e = exp1.pop_front();
            chk("res_crc1", 64'(res_crc), 64'(e.crc));
            chk("res_err1", 64'(res_err), 64'(e.err));
          end
        end
        hs_cyc = cyc;
        vcnt   = 0;
        if (rand_stall) stall = $urandom_range(0, 3);
      end
      pv = res_valid; pr = res_ready; pcrc = res_crc; pid = res_id; perr = res_err;
    end
    @(posedge clk);
    #1;
    if (a0 && q0.size() > 0) void'(q0.pop_front());
    if (a1 && q1.size() > 0) void'(q1.pop_front());
    req0_tvalid = (q0.size() > 0) && (int'($urandom_range(0, 99)) < dens);
    req1_tvalid = (q1.size() > 0) && (int'($urandom_range(0, 99)) < dens);
    req0_tdata  = (q0.size() > 0) ? q0[0].d    : 64'd0;
    req0_tlast  = (q0.size() > 0) ? q0[0].last : 1'b0;
    req1_tdata  = (q1.size() > 0) ? q1[0].d    : 64'd0;
    req1_tlast  = (q1.size() > 0) ? q1[0].last : 1'b0;
    res_ready   = (vcnt >= stall);
  endtask

  task automatic run_done(input int budget);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + exp0.size() + exp1.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(q0.size() + q1.size() + exp0.size() + exp1.size()), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, r, n;
    clear_model();
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_no_tready", 64'(req0_tready | req1_tready), 64'd0);
    chk("idle_no_init",   64'(eng_init), 64'd0);

    // Simultaneous requests: req0 first after reset, then req1.
    for (int i = 1; i <= 3; i++) push(0, 64'(i), i == 3);
    for (int i = 10; i <= 12; i++) push(1, 64'(i), i == 12);
    run_done(200);
    chk("rr_count", 64'(rlog.size()), 64'd2);
    if (rlog.size() >= 2) begin
      chk("rr_first_id",  64'(rlog[0].id), 64'd0);
      chk("rr_second_id", 64'(rlog[1].id), 64'd1);
    end

    // Single zero word from req0.
    rlog.delete();
    push(0, 64'd0, 1'b1);
    run_done(100);
    chk("single_count", 64'(rlog.size()), 64'd1);
    if (rlog.size() >= 1) begin
      chk("single_crc", 64'(rlog[0].crc), 64'(crc_step(16'hFFFF, 64'd0)));
      chk("single_id",  64'(rlog[0].id),  64'd0);
      chk("single_err", 64'(rlog[0].err), 64'd0);
    end

    // Gapped frame, consumer stalls 5 cycles; a second frame waits behind it.
    dens = 50; stall = 5;
    for (int i = 0; i < 3; i++) push(0, {$urandom, $urandom}, i == 2);
    for (int i = 0; i < 2; i++) push(1, {$urandom, $urandom}, i == 1);
    run_done(400);
    dens = 100; stall = 0;

    // Truncation: six words without tlast until the last one.
    rlog.delete();
    for (int i = 1; i <= 6; i++) push(1, {$urandom, 32'(i)}, i == 6);
    run_done(200);
    chk("trunc_count", 64'(rlog.size()), 64'd2);
    if (rlog.size() >= 2) begin
      chk("trunc_err_first",  64'(rlog[0].err), 64'd1);
      chk("trunc_err_second", 64'(rlog[1].err), 64'd0);
    end

    // Randomized traffic across both requesters.
    dens = 70; rand_stall = 1;
    for (int f = 0; f < 40; f++) begin
      r   = $urandom_range(0, 1);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) push(r, {$urandom, $urandom}, i == len - 1);
    end
    run_done(6000);
    dens = 100; rand_stall = 0; stall = 0;

    // Reset in the middle of a frame, then a clean frame.
    clear_model();
    for (int i = 0; i < 3; i++) push(0, {$urandom, $urandom}, i == 2);
    n = 0;
    while (nacc0 < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("reset_reach_feed", 64'(nacc0), 64'd2);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    clear_model();
    req0_tvalid = 1'b0; req1_tvalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    push(0, 64'h0F0F_F0F0_5A5A_A5A5, 1'b1);
    run_done(200);
    chk("post_reset_count", 64'(rlog.size()), 64'd1);
    if (rlog.size() >= 1)
      chk("post_reset_crc", 64'(rlog[0].crc),
          64'(crc_step(crc_step(16'hFFFF, 64'hDEAD_BEEF_0123_4567), 64'h0F0F_F0F0_5A5A_A5A5)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
